// File: rtl/riscv_fetch_seq.sv
// ---------------------------------------------------------------------------
// riscv_fetch_seq
//
// Minimal RV32I fetch sequencer used as the core-side responder on the
// instruction interface. It holds the program counter, consumes one
// instruction per cycle in which instr_valid is high, resolves JAL targets
// and raises a sticky trap on illegal, misaligned-target or EBREAK
// instructions. Once trapped only reset brings it back.
//
// Parameters:
//   RESET_PC     value loaded into pc on reset
//   EBREAK_TRAP  1: EBREAK (32'h0010_0073) traps; 0: EBREAK is sequential
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous, active-high reset
//   instr_valid  instr holds the instruction at the current pc this cycle
//   instr        32-bit instruction word for the current pc
//   pc           registered program counter
//   trap         registered sticky trap flag
//   trap_cause   0 none, 1 illegal, 2 misaligned target, 3 ebreak
//   retired      count of accepted non-trapping instructions (wraps)
//
// States:
//   S_RUN     | accepting instructions, pc advances on each accept
//   S_TRAPPED | trap latched, all inputs ignored until reset
// ---------------------------------------------------------------------------
module riscv_fetch_seq #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          EBREAK_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic [31:0] pc,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] retired
);

  typedef enum logic {
    S_RUN     = 1'b0,
    S_TRAPPED = 1'b1
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd2;
  localparam logic [1:0] CAUSE_EBREAK   = 2'd3;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  // registered state
  state_t      state_q,   state_d;
  logic [31:0] pc_q,      pc_d;
  logic        trap_q,    trap_d;
  logic [1:0]  cause_q,   cause_d;
  logic [31:0] retired_q, retired_d;

  // decode results
  logic [6:0]  opcode;
  logic        opcode_known;
  logic [31:0] jal_imm;
  logic [31:0] jal_target;
  logic [31:0] pc_seq;
  logic        dec_trap;
  logic [1:0]  dec_cause;
  logic [31:0] dec_pc;

  assign opcode     = instr[6:0];
  assign jal_imm    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                       instr[30:21], 1'b0};
  assign jal_target = pc_q + jal_imm;
  assign pc_seq     = pc_q + 32'd4;

  always_comb begin
    opcode_known = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM: opcode_known = 1'b1;
      default:                                      opcode_known = 1'b0;
    endcase
  end

  // Decode is evaluated unconditionally; its result only reaches state when
  // instr_valid is high, so garbage on instr while idle is harmless.
  // JALR and BRANCH are deliberately not resolved and fall through to pc+4.
  always_comb begin
    dec_trap  = 1'b0;
    dec_cause = CAUSE_NONE;
    dec_pc    = pc_seq;
    if ((instr[1:0] != 2'b11) || !opcode_known) begin
      dec_trap  = 1'b1;
      dec_cause = CAUSE_ILLEGAL;
    end else if (EBREAK_TRAP && (instr == EBREAK_WORD)) begin
      dec_trap  = 1'b1;
      dec_cause = CAUSE_EBREAK;
    end else if (opcode == OP_JAL) begin
      if (jal_target[1:0] != 2'b00) begin
        dec_trap  = 1'b1;
        dec_cause = CAUSE_MISALIGN;
      end else begin
        dec_pc = jal_target;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RUN;
      pc_q      <= RESET_PC;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    trap_d    = trap_q;
    cause_d   = cause_q;
    retired_d = retired_q;
    case (state_q)
      S_RUN: begin
        if (instr_valid) begin
          if (dec_trap) begin
            // pc stays on the faulting instruction
            state_d = S_TRAPPED;
            trap_d  = 1'b1;
            cause_d = dec_cause;
          end else begin
            pc_d      = dec_pc;
            retired_d = retired_q + 32'd1;
          end
        end
      end
      S_TRAPPED: begin
        state_d = S_TRAPPED;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  assign pc         = pc_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_riscv_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_riscv_fetch_seq
//
// Three instances with different parameters share clk and reset:
//   u0: RESET_PC=0,           EBREAK_TRAP=1  (JAL, illegal, misaligned, ebreak)
//   u1: RESET_PC=0x0000_1000, EBREAK_TRAP=0  (ADDI stream, ebreak sequential,
//                                             idle freeze, X while idle)
//   u2: RESET_PC=0xFFFF_FFF8, EBREAK_TRAP=1  (pc wrap, unknown opcode)
// The driver pushes hand-computed expectations into a queue; a monitor
// drains the queue 1 ns after each rising edge (or right after an async
// reset event) and compares against the selected instance.
// ---------------------------------------------------------------------------
module tb_riscv_fetch_seq;

  logic        clk;
  logic        reset;
  logic [2:0]  vld;
  logic [31:0] instr;

  logic [31:0] pc_w      [3];
  logic        trap_w    [3];
  logic [1:0]  cause_w   [3];
  logic [31:0] retired_w [3];

  int n_tests;
  int n_fail;

  typedef struct {
    int          sel;
    logic [31:0] pc;
    logic        trap;
    logic [1:0]  cause;
    logic [31:0] ret;
    string       name;
  } exp_t;

  exp_t q[$];
  event chk_ev;

  riscv_fetch_seq #(.RESET_PC(32'h0000_0000), .EBREAK_TRAP(1'b1)) u0 (
    .clk(clk), .reset(reset), .instr_valid(vld[0]), .instr(instr),
    .pc(pc_w[0]), .trap(trap_w[0]), .trap_cause(cause_w[0]), .retired(retired_w[0]));

  riscv_fetch_seq #(.RESET_PC(32'h0000_1000), .EBREAK_TRAP(1'b0)) u1 (
    .clk(clk), .reset(reset), .instr_valid(vld[1]), .instr(instr),
    .pc(pc_w[1]), .trap(trap_w[1]), .trap_cause(cause_w[1]), .retired(retired_w[1]));

  riscv_fetch_seq #(.RESET_PC(32'hFFFF_FFF8), .EBREAK_TRAP(1'b1)) u2 (
    .clk(clk), .reset(reset), .instr_valid(vld[2]), .instr(instr),
    .pc(pc_w[2]), .trap(trap_w[2]), .trap_cause(cause_w[2]), .retired(retired_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] ADDI    = 32'h0010_0093;
  localparam logic [31:0] EBREAK  = 32'h0010_0073;
  localparam logic [31:0] JAL_P16 = 32'h0100_006F;
  localparam logic [31:0] JAL_M8  = 32'hFF9F_F06F;
  localparam logic [31:0] JAL_P2  = 32'h0020_006F;
  localparam logic [31:0] LUI     = 32'h0000_00B7;
  localparam logic [31:0] BAD_OPC = 32'h0000_002B;
  localparam logic [31:0] ZERO    = 32'h0000_0000;

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      n_tests++;
      if (pc_w[e.sel] !== e.pc || trap_w[e.sel] !== e.trap ||
          cause_w[e.sel] !== e.cause || retired_w[e.sel] !== e.ret) begin
        n_fail++;
        $display("FAIL %s (u%0d): got pc=%h trap=%b cause=%0d retired=%0d, want pc=%h trap=%b cause=%0d retired=%0d",
                 e.name, e.sel, pc_w[e.sel], trap_w[e.sel], cause_w[e.sel], retired_w[e.sel],
                 e.pc, e.trap, e.cause, e.ret);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    drain();
  end

  initial forever begin
    @(chk_ev);
    #1;
    drain();
  end

  // Drive one cycle on instance sel and queue the state expected after the edge.
  task automatic step(input int sel, input logic v, input logic [31:0] ins,
                      input logic [31:0] epc, input logic et, input logic [1:0] ec,
                      input logic [31:0] er, input string nm);
    @(negedge clk);
    vld   = 3'b000;
    if (v) vld[sel] = 1'b1;
    instr = ins;
    q.push_back('{sel, epc, et, ec, er, nm});
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    vld   = 3'b000;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    vld     = 3'b000;
    instr   = ZERO;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    step(0, 1'b0, ZERO, 32'h0000_0000, 1'b0, 2'd0, 32'd0, "reset_u0");
    step(1, 1'b0, ZERO, 32'h0000_1000, 1'b0, 2'd0, 32'd0, "reset_u1");
    step(2, 1'b0, ZERO, 32'hFFFF_FFF8, 1'b0, 2'd0, 32'd0, "reset_u2");

    // u1: sequential stream, EBREAK sequential, idle freeze, X while idle
    step(1, 1'b1, ADDI,   32'h0000_1004, 1'b0, 2'd0, 32'd1, "addi_1");
    step(1, 1'b1, ADDI,   32'h0000_1008, 1'b0, 2'd0, 32'd2, "addi_2");
    step(1, 1'b1, ADDI,   32'h0000_100C, 1'b0, 2'd0, 32'd3, "addi_3");
    step(1, 1'b1, EBREAK, 32'h0000_1010, 1'b0, 2'd0, 32'd4, "ebreak_seq");
    for (int i = 0; i < 5; i++)
      step(1, 1'b0, ADDI, 32'h0000_1010, 1'b0, 2'd0, 32'd4, "idle_freeze");
    step(1, 1'b1, ADDI,   32'h0000_1014, 1'b0, 2'd0, 32'd5, "addi_resume");
    step(1, 1'b0, 32'bx,  32'h0000_1014, 1'b0, 2'd0, 32'd5, "x_idle");

    // u2: pc wrap, then unknown opcode traps as illegal
    step(2, 1'b1, ADDI,    32'hFFFF_FFFC, 1'b0, 2'd0, 32'd1, "wrap_1");
    step(2, 1'b1, ADDI,    32'h0000_0000, 1'b0, 2'd0, 32'd2, "wrap_2");
    step(2, 1'b1, LUI,     32'h0000_0004, 1'b0, 2'd0, 32'd3, "lui");
    step(2, 1'b1, BAD_OPC, 32'h0000_0004, 1'b1, 2'd1, 32'd3, "bad_opcode");

    // u0: JAL forward/back, illegal word, sticky trap
    step(0, 1'b1, JAL_P16, 32'h0000_0010, 1'b0, 2'd0, 32'd1, "jal_p16");
    step(0, 1'b1, JAL_M8,  32'h0000_0008, 1'b0, 2'd0, 32'd2, "jal_m8");
    step(0, 1'b1, ZERO,    32'h0000_0008, 1'b1, 2'd1, 32'd2, "illegal_zero");
    step(0, 1'b1, ADDI,    32'h0000_0008, 1'b1, 2'd1, 32'd2, "trapped_hold_1");
    step(0, 1'b1, ADDI,    32'h0000_0008, 1'b1, 2'd1, 32'd2, "trapped_hold_2");

    reset_pulse();
    step(0, 1'b0, ZERO,   32'h0000_0000, 1'b0, 2'd0, 32'd0, "reset2_u0");
    step(1, 1'b0, ZERO,   32'h0000_1000, 1'b0, 2'd0, 32'd0, "reset2_u1");
    step(0, 1'b1, JAL_P2, 32'h0000_0000, 1'b1, 2'd2, 32'd0, "jal_misalign");
    step(0, 1'b1, ADDI,   32'h0000_0000, 1'b1, 2'd2, 32'd0, "misalign_hold");

    // bump u1 so its async reset return is visible
    step(1, 1'b1, ADDI,   32'h0000_1004, 1'b0, 2'd0, 32'd1, "addi_pre_areset");

    // mid-cycle async reset: checked 1 ns later, well before the next rising edge
    @(negedge clk);
    vld = 3'b000;
    #2;
    reset = 1'b1;
    q.push_back('{0, 32'h0000_0000, 1'b0, 2'd0, 32'd0, "async_reset_u0"});
    q.push_back('{1, 32'h0000_1000, 1'b0, 2'd0, 32'd0, "async_reset_u1"});
    -> chk_ev;
    @(negedge clk);
    reset = 1'b0;

    step(0, 1'b1, EBREAK, 32'h0000_0000, 1'b1, 2'd3, 32'd0, "ebreak_trap");
    step(0, 1'b1, ADDI,   32'h0000_0000, 1'b1, 2'd3, 32'd0, "ebreak_hold");

    @(negedge clk);
    vld = 3'b000;
    @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending expectations, want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_fetch_seq.md
Name: riscv_fetch_seq

Overview:
- Core-side responder for the riscv instruction interface. The bench drives `instr`; this block produces `pc` and `trap`.
- Acts as a minimal RV32I fetch sequencer:
  - holds the program counter;
  - consumes one instruction per accepted cycle;
  - resolves JAL targets;
  - raises a sticky trap on illegal, misaligned or EBREAK instructions.
- Used as the DUT-side stand-in so the riscv agent driver and monitor can be closed-loop tested before the real core lands.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into `pc` on reset.
- EBREAK_TRAP, 1, 1 = EBREAK (32'h0010_0073) raises a trap; 0 = EBREAK treated as sequential.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- instr_valid  input  1  `instr` holds the instruction at the current `pc` this cycle.
- instr  input  32  instruction word for the current `pc`.
- pc  output  32  current program counter, registered.
- trap  output  1  sticky trap flag, registered.
- trap_cause  output  2  0=none, 1=illegal, 2=misaligned target, 3=ebreak; valid while trap=1.
- retired  output  32  count of accepted non-trapping instructions; wraps modulo 2^32.

Behaviour:
- Reset (asynchronous, active-high, effective immediately including mid-operation):
  - pc=RESET_PC, trap=0, trap_cause=0, retired=0.
  - No pending state survives reset.
- States: RUN and TRAPPED. Reset enters RUN.
- RUN, instr_valid=0: all registers hold.
- RUN, instr_valid=1: the instruction is accepted and decoded combinationally. Results register on the same rising edge (one-cycle latency to the new pc/trap).
- Decode rules, in priority order:
  1. instr[1:0]!=2'b11 -> illegal.
  2. opcode=instr[6:0] not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011 OP-IMM, 0110011 OP, 0001111 FENCE, 1110011 SYSTEM} -> illegal.
  3. instr==32'h0010_0073 and EBREAK_TRAP=1 -> ebreak.
  4. JAL: imm = sign-extended {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}; target = pc + imm, mod 2^32.
     - target[1:0]!=0 -> misaligned.
     - Otherwise pc<=target.
  5. All other legal opcodes: pc<=pc+4, mod 2^32 (wraps 32'hFFFF_FFFC -> 0).
     - JALR and BRANCH are not resolved by this block; they fall through to pc+4.
- Non-trapping accept: retired<=retired+1.
- Trapping accept:
  - pc holds the faulting address;
  - trap<=1, trap_cause<=cause;
  - retired unchanged;
  - state goes to TRAPPED.
- TRAPPED:
  - `instr` and `instr_valid` are ignored.
  - pc, trap, trap_cause and retired all hold.
  - Only reset exits.
- trap_cause is 0 whenever trap=0.
- No X propagation: an X on instr while instr_valid=0 must not affect state.

Test Plan:
- Reset with RESET_PC=32'h0000_1000, then 3 accepted ADDI (32'h0010_0093) -> pc 1004, 1008, 100C on successive edges; retired=3; trap=0.
- JAL x0,+16 (32'h0100_006F) at pc=0 -> pc=32'h10 one edge later.
  - Follow with JAL -8 (32'hFF9F_F06F) -> pc=32'h08.
  - retired=2.
- Illegal word 32'h0000_0000 at pc=0x8 -> trap=1, trap_cause=1, pc stays 0x8.
  - Further valid ADDIs leave pc, retired and trap unchanged.
- JAL with imm=+2 (32'h0020_006F) -> trap_cause=2, pc unchanged.
- EBREAK with EBREAK_TRAP=1 -> trap_cause=3.
  - With EBREAK_TRAP=0 -> pc+4 and retired increments.
- Toggle instr_valid low for 5 cycles mid-stream -> pc and retired frozen.
  - Assert reset asynchronously while TRAPPED, mid-cycle -> outputs return to reset values immediately, before the next clk edge.
- RESET_PC=32'hFFFF_FFF8, two ADDIs -> pc FFFF_FFFC, then 0000_0000.
